// File: rtl/mure_pkg.sv
// rtl/mure_pkg.sv - shared itype encodings plus branch-map record and reason types.
package mure_pkg;

  localparam int ITYPE_LEN      = 3;
  localparam int BM_LEN_DEFAULT = 31;
  localparam int BM_MAP_MAX     = 31;
  localparam int BM_IADDR_MAX   = 64;
  localparam int BM_CNT_LEN     = 6;

  typedef enum logic [ITYPE_LEN-1:0] {
    STD        = 3'd0,
    EXC        = 3'd1,
    INT        = 3'd2,
    ERET       = 3'd3,
    NTB        = 3'd4,
    TB         = 3'd5,
    UIJ        = 3'd6,
    ITYPE_RSVD = 3'd7
  } itype_e;

  typedef enum logic [1:0] {
    FULL    = 2'd0,
    DISCON  = 2'd1,
    FLUSH   = 2'd2,
    TIMEOUT = 2'd3
  } bm_reason_e;

  // Fields are sized for the largest supported map/address; the top trims them.
  typedef struct packed {
    logic [BM_MAP_MAX-1:0]   branch_map;
    logic [BM_CNT_LEN-1:0]   branches;
    bm_reason_e              reason;
    itype_e                  itype;
    logic [BM_IADDR_MAX-1:0] iaddr;
  } bm_record_t;

endpackage

// File: rtl/bm_out_reg.sv
// rtl/bm_out_reg.sv - one-entry valid/ready holding register for branch-map records.
module bm_out_reg
  import mure_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  bm_record_t rec_i,
  input  logic       ready_i,
  output logic       valid_o,
  output bm_record_t rec_o
);

  logic       valid_q;
  bm_record_t rec_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      rec_q   <= rec_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign rec_o   = rec_q;

endmodule

// File: rtl/itype_branch_map.sv
// rtl/itype_branch_map.sv - accumulates branch outcomes into map records (FULL/DISCON/FLUSH).
// Optional idle-timeout flush enabled by defining BRANCH_MAP_TIMEOUT_EN.
module itype_branch_map
  import mure_pkg::*;
#(
  parameter int BRANCH_MAP_LEN = BM_LEN_DEFAULT,
  parameter int IADDR_LEN      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  itype_e                    itype_i,
  input  logic [IADDR_LEN-1:0]      iaddr_i,
  input  logic                      flush_i,
  output logic                      map_valid_o,
  input  logic                      map_ready_i,
  output logic [BRANCH_MAP_LEN-1:0] branch_map_o,
  output logic [5:0]                branches_o,
  output bm_reason_e                reason_o,
  output itype_e                    itype_o,
  output logic [IADDR_LEN-1:0]      iaddr_o
);

  typedef enum logic {EMPTY, ACCUM} state_e;

  state_e                    state_q, state_d;
  logic [BRANCH_MAP_LEN-1:0] map_q, map_d;
  logic [5:0]                count_q, count_d;
  logic                      flush_pend_q, flush_pend_d;
  logic                      accept, flush_req, emit;
  bm_record_t                rec, out_rec;

`ifdef BRANCH_MAP_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  assign ready_o   = ~map_valid_o | map_ready_i;
  assign accept    = valid_i & ready_o;
  assign flush_req = flush_i | flush_pend_q;

  always_comb begin
    map_d   = map_q;
    count_d = count_q;
    emit    = 1'b0;
    rec     = '0;
    if (accept) begin
      case (itype_i)
        NTB, TB: begin
          for (int i = 0; i < BRANCH_MAP_LEN; i++)
            if (count_q == 6'(i)) map_d[i] = (itype_i == NTB);
          count_d = count_q + 6'd1;
          if (count_d == 6'(BRANCH_MAP_LEN)) begin
            emit            = 1'b1;
            rec.branch_map  = BM_MAP_MAX'(map_d);
            rec.branches    = count_d;
            rec.reason      = FULL;
            rec.itype       = itype_i;
            rec.iaddr       = BM_IADDR_MAX'(iaddr_i);
            map_d           = '0;
            count_d         = '0;
          end
        end
        EXC, INT, ERET, UIJ: begin
          emit            = 1'b1;
          rec.branch_map  = BM_MAP_MAX'(map_q);
          rec.branches    = count_q;
          rec.reason      = DISCON;
          rec.itype       = itype_i;
          rec.iaddr       = BM_IADDR_MAX'(iaddr_i);
          map_d           = '0;
          count_d         = '0;
        end
        default: ;
      endcase
    end
    // Flush sees the map after this cycle's branch, and yields to an input-driven emission.
    if (ready_o && flush_req && !emit && count_d != 6'd0) begin
      emit            = 1'b1;
      rec.branch_map  = BM_MAP_MAX'(map_d);
      rec.branches    = count_d;
      rec.reason      = FLUSH;
      rec.itype       = STD;
      map_d           = '0;
      count_d         = '0;
    end
    flush_pend_d = flush_req & ~ready_o;
`ifdef BRANCH_MAP_TIMEOUT_EN
    timer_d = timer_q;
    if (emit || accept || state_q == EMPTY) begin
      timer_d = '0;
    end else if (timer_q + 32'd1 >= 32'(TIMEOUT_CYCLES)) begin
      timer_d = 32'(TIMEOUT_CYCLES);
      if (ready_o) begin
        emit            = 1'b1;
        rec.branch_map  = BM_MAP_MAX'(map_q);
        rec.branches    = count_q;
        rec.reason      = TIMEOUT;
        rec.itype       = STD;
        map_d           = '0;
        count_d         = '0;
        timer_d         = '0;
      end
    end else begin
      timer_d = timer_q + 32'd1;
    end
`endif
    state_d = (count_d == 6'd0) ? EMPTY : ACCUM;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= EMPTY;
      map_q        <= '0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
`ifdef BRANCH_MAP_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      map_q        <= map_d;
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
`ifdef BRANCH_MAP_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

  bm_out_reg u_out_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (emit),
    .rec_i   (rec),
    .ready_i (map_ready_i),
    .valid_o (map_valid_o),
    .rec_o   (out_rec)
  );

  assign branch_map_o = out_rec.branch_map[BRANCH_MAP_LEN-1:0];
  assign branches_o   = out_rec.branches;
  assign reason_o     = out_rec.reason;
  assign itype_o      = out_rec.itype;
  assign iaddr_o      = out_rec.iaddr[IADDR_LEN-1:0];

endmodule

// File: tb/tb_itype_branch_map.sv
// tb/tb_itype_branch_map.sv - scoreboard bench for itype_branch_map with a queue-based reference model.
module tb_itype_branch_map;
  import mure_pkg::*;

  localparam int LEN = 31;
  localparam int AW  = 64;
  localparam int TC  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  itype_e        itype = STD;
  logic [AW-1:0] iaddr = '0;
  logic          flush = 1'b0;
  logic          map_ready = 1'b1;
  logic          ready_o, map_valid_o;
  logic [LEN-1:0] branch_map_o;
  logic [5:0]    branches_o;
  bm_reason_e    reason_o;
  itype_e        itype_o;
  logic [AW-1:0] iaddr_o;

  always #5 clk = ~clk;

  itype_branch_map #(.BRANCH_MAP_LEN(LEN), .IADDR_LEN(AW), .TIMEOUT_CYCLES(TC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready_o),
    .itype_i(itype), .iaddr_i(iaddr), .flush_i(flush),
    .map_valid_o(map_valid_o), .map_ready_i(map_ready),
    .branch_map_o(branch_map_o), .branches_o(branches_o), .reason_o(reason_o),
    .itype_o(itype_o), .iaddr_o(iaddr_o)
  );

  typedef struct {
    logic [LEN-1:0] map;
    int             n;
    logic [1:0]     reason;
    logic [2:0]     it;
    logic [AW-1:0]  addr;
  } exp_t;

  exp_t expq[$];
  bit   bits[$];
  bit   mv, pend;
  int   idle;
  int   checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [LEN-1:0] pack_bits();
    logic [LEN-1:0] m = '0;
    foreach (bits[i]) m[i] = bits[i];
    return m;
  endfunction

  task automatic push_rec(input logic [1:0] r, input logic [2:0] it, input logic [AW-1:0] a);
    exp_t e;
    e.map = pack_bits(); e.n = bits.size(); e.reason = r; e.it = it; e.addr = a;
    expq.push_back(e);
    bits.delete();
  endtask

  // Reference model: branch outcomes kept as a plain queue, records queued as they are emitted.
  always @(negedge clk) begin
    bit rdy, acc, pf, emitted;
    if (!rst_n) begin
      expq.delete(); bits.delete(); mv = 0; pend = 0; idle = 0;
    end else begin
      rdy = !mv || map_ready;
      chk("ready_o", 64'(ready_o), 64'(rdy));
      chk("map_valid_o", 64'(map_valid_o), 64'(mv));
      emitted = 0;
      acc = valid && rdy;
      pf = pend || flush;
      if (acc) begin
        case (itype)
          NTB, TB: begin
            bits.push_back(itype == NTB);
            if (bits.size() == LEN) begin push_rec(2'd0, 3'(itype), iaddr); emitted = 1; end
          end
          EXC, INT, ERET, UIJ: begin push_rec(2'd1, 3'(itype), iaddr); emitted = 1; end
          default: ;
        endcase
      end
      if (rdy) begin
        if (pf && !emitted && bits.size() > 0) begin push_rec(2'd2, 3'd0, '0); emitted = 1; end
        pend = 0;
      end else begin
        pend = pf;
      end
`ifdef BRANCH_MAP_TIMEOUT_EN
      if (emitted || acc || bits.size() == 0) idle = 0;
      else begin
        idle++;
        if (idle >= TC && rdy) begin push_rec(2'd3, 3'd0, '0); emitted = 1; idle = 0; end
      end
`endif
      if (emitted) mv = 1;
      else if (mv && map_ready) mv = 0;
    end
  end

  // Monitor: compares the presented record every cycle it is valid, pops on handshake.
  always @(negedge clk) begin
    if (rst_n && map_valid_o) begin
      if (expq.size() == 0) begin
        chk("unexpected_record", 64'(map_valid_o), 64'd0);
      end else begin
        chk("branch_map", 64'(branch_map_o), 64'(expq[0].map));
        chk("branches", 64'(branches_o), 64'(expq[0].n));
        chk("reason", 64'(reason_o), 64'(expq[0].reason));
        chk("itype", 64'(itype_o), 64'(expq[0].it));
        chk("iaddr", 64'(iaddr_o), 64'(expq[0].addr));
        if (map_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic cyc(input bit v, input itype_e it, input logic [AW-1:0] a, input bit f, input bit mr);
    @(posedge clk); #1;
    valid = v; itype = it; iaddr = a; flush = f; map_ready = mr;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, STD, '0, 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_map_valid"}, 64'(map_valid_o), 64'd0);
    chk({tag, "_branch_map"}, 64'(branch_map_o), 64'd0);
    chk({tag, "_branches"}, 64'(branches_o), 64'd0);
    chk({tag, "_reason"}, 64'(reason_o), 64'(FULL));
    chk({tag, "_itype"}, 64'(itype_o), 64'(STD));
    chk({tag, "_iaddr"}, 64'(iaddr_o), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst_n = 0; valid = 0; flush = 0; map_ready = 1;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    do_reset();
    // Branch stream closed by ERET
    cyc(1, NTB, 64'h100, 0, 1); cyc(1, TB, 64'h104, 0, 1); cyc(1, NTB, 64'h108, 0, 1);
    cyc(1, ERET, 64'h200, 0, 1); idle_cycles(3);
    // Fill to capacity, then a 32nd branch flushed alone
    for (int i = 0; i < LEN; i++) cyc(1, TB, 64'(32'h1000 + 4 * i), 0, 1);
    cyc(1, TB, 64'h2000, 0, 1); cyc(0, STD, '0, 1, 1); idle_cycles(3);
    // Exception on an empty map after reset
    do_reset();
    cyc(1, EXC, 64'h400, 0, 1); idle_cycles(3);
    // Backpressure: record held, NTB waits, then accepted as map_ready rises
    cyc(1, NTB, 64'h500, 0, 0); cyc(1, INT, 64'h504, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, NTB, 64'h508, 0, 0);
    cyc(1, NTB, 64'h508, 0, 1); cyc(0, STD, '0, 0, 0);
    cyc(0, STD, '0, 1, 0); cyc(0, STD, '0, 0, 0); idle_cycles(3);
    // Flush cases
    cyc(1, TB, 64'h600, 0, 1); cyc(1, NTB, 64'h604, 0, 1); cyc(0, STD, '0, 1, 1);
    cyc(0, STD, '0, 1, 1); idle_cycles(2);
    cyc(1, NTB, 64'h700, 0, 1); cyc(1, UIJ, 64'h704, 1, 1); idle_cycles(3);
    // Timeout after a lone branch, then asynchronous reset with a record pending
    cyc(1, TB, 64'h800, 0, 1); idle_cycles(TC + 4);
    cyc(1, NTB, 64'h900, 0, 0); cyc(1, EXC, 64'h904, 0, 0); cyc(1, TB, 64'h908, 0, 0);
    @(posedge clk); #3; rst_n = 0; valid = 0;
    #1 check_reset_outputs("async");
    chk("async_ready", 64'(ready_o), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) < 7, itype_e'(3'($urandom_range(0, 7))), {$urandom, $urandom},
          $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    idle_cycles(20);
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
